// File: rtl/control_rsa.sv
// rtl/control_rsa.sv - RSA key generation (n, d) and square-and-multiply modular exponentiation
module control_rsa #(
    parameter int WIDTH = 128
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   p,
    input  logic [WIDTH-1:0]   q,
    input  logic               reset_inverter,
    input  logic               reset_mod_exp,
    input  logic               encrypt_decrypt,
    input  logic [2*WIDTH-1:0] msg_in,
    output logic               inverter_finish,
    output logic [2*WIDTH-1:0] msg_out,
    output logic               mod_exp_finish
);

    localparam int NW = 2 * WIDTH;
    localparam int TW = NW + 2;
    localparam int CW = $clog2(NW) + 1;
    localparam logic [16:0] E_PUB = 17'd65537;

    typedef enum logic [1:0] {K_IDLE, K_MUL, K_DIV, K_EUC} kstate_t;
    typedef enum logic [1:0] {M_IDLE, M_RED, M_SQR, M_MUL} mstate_t;

    kstate_t r_kstate, w_knext;
    mstate_t r_mstate, w_mnext;

    logic [WIDTH-1:0]     r_p, r_q;
    logic [NW-1:0]        r_n, r_phi, r_d, r_shift;
    logic [16:0]          r_rem, r_ea, r_eb;
    logic signed [TW-1:0] r_ta, r_tb;
    logic [CW-1:0]        r_cnt;

    logic [NW-1:0]        r_m, r_exp, r_mul_a, r_mul_b, r_acc;
    logic [CW-1:0]        r_mcnt, r_bcnt;

    logic [NW-1:0]        w_n, w_phi, w_quo_nx, w_d, w_prod;
    logic [17:0]          w_rem_sh;
    logic [16:0]          w_rem_nx, w_ediv, w_eq, w_er;
    logic                 w_qbit, w_div_last, w_mul_last, w_exp_last, w_advance;
    logic signed [TW-1:0] w_eq_ext, w_tnext, w_neg_q;
    logic [NW+1:0]        w_n_ext, w_acc_sh, w_acc_s1;

    assign w_n   = NW'(r_p) * NW'(r_q);
    assign w_phi = NW'(r_p - WIDTH'(1)) * NW'(r_q - WIDTH'(1));

    // First Euclid quotient phi / e is wide, so it is produced one bit per cycle
    assign w_rem_sh   = {r_rem, r_shift[NW-1]};
    assign w_qbit     = (w_rem_sh >= {1'b0, E_PUB});
    assign w_rem_nx   = w_qbit ? 17'(w_rem_sh - {1'b0, E_PUB}) : w_rem_sh[16:0];
    assign w_quo_nx   = {r_shift[NW-2:0], w_qbit};
    assign w_neg_q    = -$signed({2'b00, w_quo_nx});
    assign w_div_last = (r_cnt == CW'(NW - 1));

    // Remaining steps operate on values below e, so a narrow divider suffices
    assign w_ediv   = (r_eb == '0) ? 17'd1 : r_eb;
    assign w_eq     = r_ea / w_ediv;
    assign w_er     = r_ea % w_ediv;
    assign w_eq_ext = $signed(TW'(w_eq));
    assign w_tnext  = r_ta - w_eq_ext * r_tb;
    assign w_d      = (r_ea != 17'd1) ? '0 :
                      r_ta[TW-1] ? NW'(r_ta + $signed({2'b00, r_phi})) : NW'(r_ta);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_kstate <= K_IDLE;
        else          r_kstate <= w_knext;
    end

    always_comb begin
        w_knext = r_kstate;
        if (reset_inverter) begin
            w_knext = K_MUL;
        end else begin
            case (r_kstate)
                K_MUL:   w_knext = K_DIV;
                K_DIV:   if (w_div_last) w_knext = K_EUC;
                K_EUC:   if (r_eb == '0) w_knext = K_IDLE;
                default: w_knext = K_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p <= '0; r_q <= '0; r_n <= '0; r_phi <= '0; r_d <= '0; r_shift <= '0;
            r_rem <= '0; r_ea <= '0; r_eb <= '0; r_ta <= '0; r_tb <= '0; r_cnt <= '0;
            inverter_finish <= 1'b0;
        end else if (reset_inverter) begin
            r_p <= p;
            r_q <= q;
            inverter_finish <= 1'b0;
        end else begin
            case (r_kstate)
                K_MUL: begin
                    r_n     <= w_n;
                    r_phi   <= w_phi;
                    r_shift <= w_phi;
                    r_rem   <= '0;
                    r_cnt   <= '0;
                end
                K_DIV: begin
                    r_shift <= w_quo_nx;
                    r_rem   <= w_rem_nx;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_div_last) begin
                        r_ea <= E_PUB;
                        r_eb <= w_rem_nx;
                        r_ta <= TW'(1);
                        r_tb <= w_neg_q;
                    end
                end
                K_EUC: begin
                    if (r_eb == '0) begin
                        r_d <= w_d;
                        inverter_finish <= 1'b1;
                    end else begin
                        r_ea <= r_eb;
                        r_eb <= w_er;
                        r_ta <= r_tb;
                        r_tb <= w_tnext;
                    end
                end
                default: ;
            endcase
        end
    end

    // acc < n and b < n keep 2*acc + b below 3n, so two conditional subtracts reduce fully
    assign w_n_ext  = {2'b00, r_n};
    assign w_acc_sh = {1'b0, r_acc, 1'b0} + (r_mul_a[NW-1] ? {2'b00, r_mul_b} : '0);
    assign w_acc_s1 = (w_acc_sh >= w_n_ext) ? w_acc_sh - w_n_ext : w_acc_sh;
    assign w_prod   = NW'((w_acc_s1 >= w_n_ext) ? w_acc_s1 - w_n_ext : w_acc_s1);

    assign w_mul_last = (r_mcnt == CW'(NW - 1));
    assign w_exp_last = (r_bcnt == CW'(NW - 1));
    assign w_advance  = (r_mstate == M_MUL) || (r_mstate == M_SQR && !r_exp[NW-1]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_mstate <= M_IDLE;
        else          r_mstate <= w_mnext;
    end

    always_comb begin
        w_mnext = r_mstate;
        if (reset_mod_exp) begin
            w_mnext = M_RED;
        end else if (r_mstate != M_IDLE && w_mul_last) begin
            if (r_mstate == M_RED)      w_mnext = M_SQR;
            else if (!w_advance)        w_mnext = M_MUL;
            else if (w_exp_last)        w_mnext = M_IDLE;
            else                        w_mnext = M_SQR;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m <= '0; r_exp <= '0; r_mul_a <= '0; r_mul_b <= '0; r_acc <= '0;
            r_mcnt <= '0; r_bcnt <= '0;
            msg_out <= '0;
            mod_exp_finish <= 1'b0;
        end else if (reset_mod_exp) begin
            r_mul_a <= msg_in;
            r_mul_b <= NW'(1);
            r_acc   <= '0;
            r_mcnt  <= '0;
            r_bcnt  <= '0;
            r_exp   <= encrypt_decrypt ? r_d : NW'(E_PUB);
            mod_exp_finish <= 1'b0;
        end else if (r_mstate != M_IDLE) begin
            r_acc   <= w_prod;
            r_mul_a <= {r_mul_a[NW-2:0], 1'b0};
            r_mcnt  <= r_mcnt + 1'b1;
            if (w_mul_last) begin
                r_acc  <= '0;
                r_mcnt <= '0;
                if (r_mstate == M_RED) begin
                    r_m     <= w_prod;
                    r_mul_a <= NW'(1);
                    r_mul_b <= NW'(1);
                end else if (!w_advance) begin
                    r_mul_a <= w_prod;
                    r_mul_b <= r_m;
                end else begin
                    r_exp  <= {r_exp[NW-2:0], 1'b0};
                    r_bcnt <= r_bcnt + 1'b1;
                    r_mul_a <= w_prod;
                    r_mul_b <= w_prod;
                    if (w_exp_last) begin
                        msg_out <= w_prod;
                        mod_exp_finish <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_control_rsa.sv
// tb/tb_control_rsa.sv - directed self-checking bench for control_rsa at WIDTH 16 and 32
module tb_control_rsa;

    localparam int KB16 = 8*16 + 16;
    localparam int XB16 = 4*16*(2*16 + 3) + 16;
    localparam int KB32 = 8*32 + 16;
    localparam int XB32 = 4*32*(2*32 + 3) + 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic [15:0] p16, q16;
    logic        ri16, rm16, ed16, if16, mf16;
    logic [31:0] m16, mo16;

    logic [31:0] p32, q32;
    logic        ri32, rm32, ed32, if32, mf32;
    logic [63:0] m32, mo32;

    int checks = 0;
    int errors = 0;

    control_rsa #(.WIDTH(16)) u16 (
        .clk(clk), .reset_n(reset_n), .p(p16), .q(q16),
        .reset_inverter(ri16), .reset_mod_exp(rm16), .encrypt_decrypt(ed16),
        .msg_in(m16), .inverter_finish(if16), .msg_out(mo16), .mod_exp_finish(mf16)
    );

    control_rsa #(.WIDTH(32)) u32 (
        .clk(clk), .reset_n(reset_n), .p(p32), .q(q32),
        .reset_inverter(ri32), .reset_mod_exp(rm32), .encrypt_decrypt(ed32),
        .msg_in(m32), .inverter_finish(if32), .msg_out(mo32), .mod_exp_finish(mf32)
    );

    function automatic logic [63:0] ref_modexp(input logic [63:0] b, input logic [63:0] e,
                                               input logic [63:0] n);
        logic [127:0] r, x;
        r = 128'd1 % n;
        x = b % n;
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = (r * x) % n;
            x = (x * x) % n;
        end
        return r[63:0];
    endfunction

    task automatic strobe_key16(input logic [15:0] pp, input logic [15:0] qq);
        @(posedge clk); #1; p16 = pp; q16 = qq; ri16 = 1'b1;
        @(posedge clk); #1; ri16 = 1'b0;
    endtask

    task automatic wait_key16(output int cyc);
        cyc = 0;
        while (if16 !== 1'b1 && cyc < 4*KB16) begin @(posedge clk); #1; cyc++; end
    endtask

    task automatic strobe_exp16(input logic [31:0] mm, input logic ed);
        @(posedge clk); #1; m16 = mm; ed16 = ed; rm16 = 1'b1;
        @(posedge clk); #1; rm16 = 1'b0;
    endtask

    task automatic wait_exp16(output int cyc);
        cyc = 0;
        while (mf16 !== 1'b1 && cyc < 2*XB16) begin @(posedge clk); #1; cyc++; end
    endtask

    task automatic exp16(input logic [31:0] mm, input logic ed, output int cyc);
        strobe_exp16(mm, ed);
        wait_exp16(cyc);
    endtask

    task automatic keygen32(input logic [31:0] pp, input logic [31:0] qq, output int cyc);
        @(posedge clk); #1; p32 = pp; q32 = qq; ri32 = 1'b1;
        @(posedge clk); #1; ri32 = 1'b0;
        cyc = 0;
        while (if32 !== 1'b1 && cyc < 4*KB32) begin @(posedge clk); #1; cyc++; end
    endtask

    task automatic exp32(input logic [63:0] mm, input logic ed, output int cyc);
        @(posedge clk); #1; m32 = mm; ed32 = ed; rm32 = 1'b1;
        @(posedge clk); #1; rm32 = 1'b0;
        cyc = 0;
        while (mf32 !== 1'b1 && cyc < 2*XB32) begin @(posedge clk); #1; cyc++; end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (if16 !== 1'b0) begin errors++; $display("FAIL reset_inv_finish: got %0b expected 0", if16); end
        checks++; if (mf16 !== 1'b0) begin errors++; $display("FAIL reset_exp_finish: got %0b expected 0", mf16); end
        checks++; if (mo16 !== 32'd0) begin errors++; $display("FAIL reset_msg_out: got %0d expected 0", mo16); end
        checks++; if (u16.r_n !== 32'd0) begin errors++; $display("FAIL reset_n_reg: got %0d expected 0", u16.r_n); end
        reset_n = 1'b1;
    endtask

    task automatic test_keygen;
        int cyc;
        strobe_key16(16'd61, 16'd53);
        wait_key16(cyc);
        checks++; if (if16 !== 1'b1) begin errors++; $display("FAIL keygen_finish: got %0b expected 1", if16); end
        checks++; if (cyc > KB16) begin errors++; $display("FAIL keygen_latency: got %0d cycles expected <= %0d", cyc, KB16); end
        checks++; if (u16.r_n !== 32'd3233) begin errors++; $display("FAIL keygen_n: got %0d expected 3233", u16.r_n); end
        checks++; if (u16.r_d !== 32'd2753) begin errors++; $display("FAIL keygen_d: got %0d expected 2753", u16.r_d); end
    endtask

    task automatic test_encrypt;
        int cyc;
        exp16(32'd65, 1'b0, cyc);
        checks++; if (mf16 !== 1'b1) begin errors++; $display("FAIL enc_finish: got %0b expected 1", mf16); end
        checks++; if (cyc > XB16) begin errors++; $display("FAIL enc_latency: got %0d cycles expected <= %0d", cyc, XB16); end
        checks++; if (mo16 !== 32'd2790) begin errors++; $display("FAIL enc_65: got %0d expected 2790", mo16); end
        exp16(32'd1, 1'b0, cyc);
        checks++; if (mo16 !== 32'd1) begin errors++; $display("FAIL enc_1: got %0d expected 1", mo16); end
        exp16(32'd3298, 1'b0, cyc);
        checks++; if (mo16 !== 32'd2790) begin errors++; $display("FAIL enc_unreduced: got %0d expected 2790", mo16); end
    endtask

    task automatic test_decrypt;
        int cyc;
        exp16(32'd2790, 1'b1, cyc);
        checks++; if (cyc > XB16) begin errors++; $display("FAIL dec_latency: got %0d cycles expected <= %0d", cyc, XB16); end
        checks++; if (mo16 !== 32'd65) begin errors++; $display("FAIL dec_2790: got %0d expected 65", mo16); end
        exp16(32'd0, 1'b1, cyc);
        checks++; if (mo16 !== 32'd0) begin errors++; $display("FAIL dec_0: got %0d expected 0", mo16); end
        exp16(32'd1, 1'b1, cyc);
        checks++; if (mo16 !== 32'd1) begin errors++; $display("FAIL dec_1: got %0d expected 1", mo16); end
    endtask

    task automatic test_hold_and_busy;
        int cyc;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (mf16 !== 1'b1 || mo16 !== 32'd1) begin errors++; $display("FAIL hold_result: got finish %0b out %0d expected 1 1", mf16, mo16); end
        checks++; if (if16 !== 1'b1) begin errors++; $display("FAIL hold_inv_finish: got %0b expected 1", if16); end
        strobe_exp16(32'd65, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (mf16 !== 1'b0 || mo16 !== 32'd1) begin errors++; $display("FAIL busy_hold: got finish %0b out %0d expected 0 1", mf16, mo16); end
        wait_exp16(cyc);
        checks++; if (mo16 !== 32'd2790) begin errors++; $display("FAIL busy_result: got %0d expected 2790", mo16); end
    endtask

    task automatic test_abort;
        int cyc;
        strobe_exp16(32'd123, 1'b0);
        repeat (100) @(posedge clk);
        strobe_exp16(32'd2790, 1'b1);
        checks++; if (mf16 !== 1'b0) begin errors++; $display("FAIL abort_exp_clear: got %0b expected 0", mf16); end
        wait_exp16(cyc);
        checks++; if (mo16 !== 32'd65 || cyc > XB16) begin errors++; $display("FAIL abort_exp: got %0d in %0d cycles expected 65", mo16, cyc); end
        strobe_key16(16'd3, 16'd5);
        checks++; if (if16 !== 1'b0) begin errors++; $display("FAIL abort_key_clear: got %0b expected 0", if16); end
        repeat (5) @(posedge clk);
        strobe_key16(16'd61, 16'd53);
        wait_key16(cyc);
        checks++; if (u16.r_n !== 32'd3233 || u16.r_d !== 32'd2753) begin errors++; $display("FAIL abort_key: got n %0d d %0d expected 3233 2753", u16.r_n, u16.r_d); end
    endtask

    task automatic test_hold_strobe;
        int cyc;
        int early;
        early = 0;
        @(posedge clk); #1; m16 = 32'd65; ed16 = 1'b0; rm16 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (mf16 !== 1'b0) early++;
        end
        rm16 = 1'b0;
        checks++; if (early != 0) begin errors++; $display("FAIL strobe_held_finish: got %0d early finishes expected 0", early); end
        wait_exp16(cyc);
        checks++; if (mo16 !== 32'd2790 || cyc > XB16) begin errors++; $display("FAIL strobe_held_result: got %0d in %0d cycles expected 2790", mo16, cyc); end
    endtask

    task automatic test_async_reset;
        int cyc;
        strobe_exp16(32'd2790, 1'b1);
        repeat (200) @(posedge clk);
        #3; reset_n = 1'b0;
        #1;
        checks++; if (mf16 !== 1'b0 || mo16 !== 32'd0) begin errors++; $display("FAIL async_outputs: got finish %0b out %0d expected 0 0", mf16, mo16); end
        checks++; if (if16 !== 1'b0) begin errors++; $display("FAIL async_inv_finish: got %0b expected 0", if16); end
        checks++; if (u16.r_n !== 32'd0 || u16.r_d !== 32'd0) begin errors++; $display("FAIL async_keys: got n %0d d %0d expected 0 0", u16.r_n, u16.r_d); end
        #20; reset_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        checks++; if (mf16 !== 1'b0 || if16 !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got exp %0b inv %0b expected 0 0", mf16, if16); end
        strobe_key16(16'd61, 16'd53);
        wait_key16(cyc);
        exp16(32'd65, 1'b0, cyc);
        checks++; if (mo16 !== 32'd2790) begin errors++; $display("FAIL post_reset_enc: got %0d expected 2790", mo16); end
    endtask

    task automatic test_roundtrip32;
        int cyc;
        logic [63:0]  n_exp, phi, c, msg, c_exp;
        logic [127:0] prod;
        n_exp = 64'(32'd4294967291) * 64'(32'd4294967279);
        phi   = 64'(32'd4294967290) * 64'(32'd4294967278);
        msg   = 64'h0123456789abcdef;
        keygen32(32'd4294967291, 32'd4294967279, cyc);
        checks++; if (if32 !== 1'b1 || cyc > KB32) begin errors++; $display("FAIL rt_keygen: got finish %0b in %0d cycles expected 1", if32, cyc); end
        checks++; if (u32.r_n !== n_exp) begin errors++; $display("FAIL rt_n: got %0h expected %0h", u32.r_n, n_exp); end
        prod = (128'(u32.r_d) * 128'd65537) % 128'(phi);
        checks++; if (prod !== 128'd1 || u32.r_d >= phi) begin errors++; $display("FAIL rt_d_inverse: got d %0h (d*e mod phi %0h) expected inverse", u32.r_d, prod); end
        c_exp = ref_modexp(msg, 64'd65537, n_exp);
        exp32(msg, 1'b0, cyc);
        c = mo32;
        checks++; if (c !== c_exp || cyc > XB32) begin errors++; $display("FAIL rt_encrypt: got %0h in %0d cycles expected %0h", c, cyc, c_exp); end
        exp32(c, 1'b1, cyc);
        checks++; if (mo32 !== msg || cyc > XB32) begin errors++; $display("FAIL rt_decrypt: got %0h in %0d cycles expected %0h", mo32, cyc, msg); end
    endtask

    task automatic test_gcd32;
        int cyc;
        keygen32(32'd131075, 32'd3, cyc);
        checks++; if (if32 !== 1'b1 || cyc > KB32) begin errors++; $display("FAIL gcd_finish: got %0b in %0d cycles expected 1", if32, cyc); end
        checks++; if (u32.r_d !== 64'd0) begin errors++; $display("FAIL gcd_d: got %0h expected 0", u32.r_d); end
        checks++; if (u32.r_n !== 64'd393225) begin errors++; $display("FAIL gcd_n: got %0d expected 393225", u32.r_n); end
    endtask

    initial begin
        p16 = '0; q16 = '0; ri16 = 1'b0; rm16 = 1'b0; ed16 = 1'b0; m16 = '0;
        p32 = '0; q32 = '0; ri32 = 1'b0; rm32 = 1'b0; ed32 = 1'b0; m32 = '0;
        test_reset();
        test_keygen();
        test_encrypt();
        test_decrypt();
        test_hold_and_busy();
        test_abort();
        test_hold_strobe();
        test_async_reset();
        test_roundtrip32();
        test_gcd32();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
